system_sysid_ext: RTL and testbench
===================================

Name: system_sysid_ext

Overview:
- Parametrised Avalon-MM system-identification and build-info slave on the system interconnect.
- Read-only ID and build timestamp, plus:
  - a free-running 64-bit cycle uptime counter with atomic high-word snapshot;
  - a seconds counter;
  - a control register;
  - software scratch registers.
- Pipelined read path with configurable latency and a readdatavalid strobe.

Parameters:
- ID_VALUE, 32'hA5A5_0001, system ID word.
- TIMESTAMP, 32'd0, build time in Unix seconds.
- ADDR_W, 3, word address width; legal range 3..6.
- NUM_SCRATCH, 2, number of scratch registers; legal range 1..(2**ADDR_W - 6).
- READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal range 1..3.
- CLK_FREQ_HZ, 50_000_000, clock frequency; sets the seconds prescaler terminal count.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  ADDR_W  word address.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  32  write data.
- byteenable  in  4  write byte lanes.
- readdata  out  32  read data; registered.
- readdatavalid  out  1  one-cycle strobe, readdata valid.

Behaviour:
- Reset: one clock `clock`; reset is asynchronous, active-low on `reset_n`. On reset assertion, all of the following clear to 0: readdata, readdatavalid, uptime, shadow, prescaler, seconds, control, scratch, read pipeline.
- No wait states. A read or write is accepted in every cycle it is asserted.
- Register map (word address, access):
  - 0: ID, RO.
  - 1: TIMESTAMP, RO.
  - 2: UPTIME_LO, RO. A read also copies uptime[63:32] into the HI shadow in the same cycle.
  - 3: UPTIME_HI, RO. Returns the shadow value.
  - 4: SECONDS, RO.
  - 5: CONTROL, RW.
    - bit0 CLEAR: write 1 pulses a clear; the bit self-clears and always reads 0.
    - bit1 FREEZE.
    - Bits 31:2 read 0.
  - 6 .. 6+NUM_SCRATCH-1: SCRATCHn, RW, per-byte via byteenable.
  - All other addresses read 0; writes to them are ignored.
- Read data sampling:
  - Data is sampled in the accept cycle, using pre-update register values.
  - It appears on readdata after READ_LATENCY cycles, with readdatavalid high for exactly that cycle.
  - Back-to-back reads give back-to-back valid strobes, in order.
  - readdata holds its last value when readdatavalid is low.
- Uptime counter:
  - 64-bit, increments by 1 each cycle unless FREEZE=1.
  - Wraps from 2**64-1 to 0 silently.
- Seconds counter:
  - The prescaler counts 0..CLK_FREQ_HZ-1.
  - At the terminal count the prescaler returns to 0 and SECONDS increments by 1.
  - 32-bit; wraps silently.
  - FREEZE holds both the prescaler and SECONDS.
- CLEAR:
  - Writing bit0=1 zeroes uptime, prescaler, SECONDS and the shadow on the next edge.
  - CLEAR beats FREEZE: counters zero, then hold while FREEZE=1.
  - A read in the CLEAR write cycle returns pre-clear values.
- Writes:
  - Byteenable applies to CONTROL and SCRATCH. For CONTROL, only lane 0 matters.
  - byteenable=0 writes nothing.
- Simultaneous read and write in one cycle:
  - Write takes effect.
  - Read returns the pre-write value.
- Shadow snapshot:
  - The shadow updates only on UPTIME_LO reads.
  - A read of UPTIME_HI without a prior UPTIME_LO read returns the stale shadow, 0 after reset.
- Reset mid-read: pipeline is flushed; no readdatavalid is issued for reads in flight.

Decomposition:
- Shared package system_sysid_pkg holds:
  - register address constants (ADDR_ID=0 .. ADDR_SCRATCH0=6);
  - CONTROL bit indices (CTRL_CLEAR=0, CTRL_FREEZE=1);
  - the readdata width constant (32).
- One natural sub-module: system_sysid_read_pipe, a READ_LATENCY-deep data/valid shift register with asynchronous reset.
- Register decode and the counters stay in the top module.

Test Plan:
- Reset release, then read address 0 and address 1 back to back, with READ_LATENCY=2 → 32'hA5A5_0001 then 32'd0, on two consecutive readdatavalid cycles exactly 2 cycles after each read.
- Force uptime to 64'h0000_0000_FFFF_FFFF via CLEAR + wait, or a small-width test parameter; read LO, then HI 5 cycles later → the HI value equals the high word at the LO read cycle, not the incremented value. Also check the wrap to 64'h1_0000_0000 across the read.
- CLK_FREQ_HZ=4: run 10 cycles → SECONDS=2. Set FREEZE, wait 20 cycles → SECONDS still 2. Write CONTROL=32'h3 → SECONDS=0 and uptime=0, both held.
- Write SCRATCH0=32'h1234_5678 with byteenable=4'b1111, then 32'hFFFF_FFFF with byteenable=4'b0101 → reads 32'h12FF_56FF. Write address 7 on the top address, ADDR_W=3, NUM_SCRATCH=1 → ignored, reads 0.
- Read and write SCRATCH1 in the same cycle, old=32'h0, new=32'hDEAD_BEEF → readdata 0; the next read returns 32'hDEAD_BEEF.
- Assert reset_n=0 one cycle after a read with READ_LATENCY=3 → readdatavalid never pulses; readdata=0 and all counters 0 after release.

Source files
------------

// File: rtl/system_sysid_pkg.sv
// Shared constants for the system-ID slave: register map, CONTROL bit positions,
// data width and a byte-lane merge helper.
package system_sysid_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [5:0] ADDR_ID        = 6'd0;
  localparam logic [5:0] ADDR_TIMESTAMP = 6'd1;
  localparam logic [5:0] ADDR_UPTIME_LO = 6'd2;
  localparam logic [5:0] ADDR_UPTIME_HI = 6'd3;
  localparam logic [5:0] ADDR_SECONDS   = 6'd4;
  localparam logic [5:0] ADDR_CONTROL   = 6'd5;
  localparam logic [5:0] ADDR_SCRATCH0  = 6'd6;

  localparam int unsigned CTRL_CLEAR  = 0;
  localparam int unsigned CTRL_FREEZE = 1;

  function automatic logic [DATA_W-1:0] apply_be(input logic [DATA_W-1:0] old_val,
                                                 input logic [DATA_W-1:0] new_val,
                                                 input logic [3:0]        be);
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_val[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/system_sysid_ext_read_pipe.sv
// LATENCY-deep data/valid shift register for the read return path. Each stage only
// captures data behind a valid beat, so the output holds its last value when idle.
module system_sysid_read_pipe #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned DW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] valid_d;
  logic [DW-1:0]      data_q [LATENCY];
  logic [DW-1:0]      data_d [LATENCY];

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign valid_d[g] = in_valid;
      assign data_d[g]  = in_valid ? in_data : data_q[g];
    end else begin : g_tail
      assign valid_d[g] = valid_q[g-1];
      assign data_d[g]  = valid_q[g-1] ? data_q[g-1] : data_q[g];
    end
  end

  // Stage registers; reset flushes any reads still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/system_sysid_ext.sv
// Avalon-MM system-ID slave: ID/build timestamp, 64-bit uptime with HI-word snapshot,
// seconds counter, CONTROL (CLEAR/FREEZE) and byte-writable scratch registers.
module system_sysid_ext
  import system_sysid_pkg::*;
#(
  parameter logic [31:0] ID_VALUE     = 32'hA5A5_0001,
  parameter logic [31:0] TIMESTAMP    = 32'd0,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned NUM_SCRATCH  = 2,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned CLK_FREQ_HZ  = 50_000_000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid
);

  localparam logic [31:0] PRESC_TC = 32'(CLK_FREQ_HZ - 1);

  logic [5:0]        addr_s;
  logic              ctrl_wr_s;
  logic              clear_s;
  logic [DATA_W-1:0] rdata_s;

  logic [63:0] uptime_q,  uptime_d;
  logic [31:0] shadow_q,  shadow_d;
  logic [31:0] presc_q,   presc_d;
  logic [31:0] seconds_q, seconds_d;
  logic        freeze_q,  freeze_d;
  logic [31:0] scratch_q [NUM_SCRATCH];
  logic [31:0] scratch_d [NUM_SCRATCH];

  assign addr_s = 6'(address);

  // CONTROL write decode; only byte lane 0 carries CLEAR/FREEZE.
  always_comb begin
    ctrl_wr_s = write && (addr_s == ADDR_CONTROL) && byteenable[0];
    clear_s   = ctrl_wr_s && writedata[CTRL_CLEAR];
  end

  // Read mux samples the current (pre-update) register values.
  always_comb begin
    rdata_s = '0;
    case (addr_s)
      ADDR_ID:        rdata_s = ID_VALUE;
      ADDR_TIMESTAMP: rdata_s = TIMESTAMP;
      ADDR_UPTIME_LO: rdata_s = uptime_q[31:0];
      ADDR_UPTIME_HI: rdata_s = shadow_q;
      ADDR_SECONDS:   rdata_s = seconds_q;
      ADDR_CONTROL:   rdata_s = {30'd0, freeze_q, 1'b0};
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (addr_s == (ADDR_SCRATCH0 + 6'(i))) begin
            rdata_s = scratch_q[i];
          end else begin
            rdata_s = rdata_s;
          end
        end
      end
    endcase
  end

  // Counter, snapshot, control and scratch next-state; CLEAR overrides FREEZE.
  always_comb begin
    uptime_d  = uptime_q;
    shadow_d  = shadow_q;
    presc_d   = presc_q;
    seconds_d = seconds_q;
    freeze_d  = freeze_q;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      scratch_d[i] = scratch_q[i];
    end

    if (read && (addr_s == ADDR_UPTIME_LO)) begin
      shadow_d = uptime_q[63:32];
    end else begin
      shadow_d = shadow_q;
    end

    if (clear_s) begin
      uptime_d  = 64'd0;
      presc_d   = 32'd0;
      seconds_d = 32'd0;
      shadow_d  = 32'd0;
    end else if (!freeze_q) begin
      uptime_d = uptime_q + 64'd1;
      if (presc_q == PRESC_TC) begin
        presc_d   = 32'd0;
        seconds_d = seconds_q + 32'd1;
      end else begin
        presc_d   = presc_q + 32'd1;
      end
    end else begin
      uptime_d = uptime_q;
    end

    if (ctrl_wr_s) begin
      freeze_d = writedata[CTRL_FREEZE];
    end else begin
      freeze_d = freeze_q;
    end

    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (write && (addr_s == (ADDR_SCRATCH0 + 6'(i)))) begin
        scratch_d[i] = apply_be(scratch_q[i], writedata, byteenable);
      end else begin
        scratch_d[i] = scratch_q[i];
      end
    end
  end

  // Register state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime_q  <= 64'd0;
      shadow_q  <= 32'd0;
      presc_q   <= 32'd0;
      seconds_q <= 32'd0;
      freeze_q  <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch_q[i] <= 32'd0;
      end
    end else begin
      uptime_q  <= uptime_d;
      shadow_q  <= shadow_d;
      presc_q   <= presc_d;
      seconds_q <= seconds_d;
      freeze_q  <= freeze_d;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch_q[i] <= scratch_d[i];
      end
    end
  end

  system_sysid_read_pipe #(
    .LATENCY (READ_LATENCY),
    .DW      (DATA_W)
  ) u_read_pipe (
    .clk       (clock),
    .rst_n     (reset_n),
    .in_valid  (read),
    .in_data   (rdata_s),
    .out_valid (readdatavalid),
    .out_data  (readdata)
  );

endmodule

// File: tb/tb_system_sysid_ext.sv
// Scoreboard bench for system_sysid_ext: a reference model predicts each read at issue
// time; a monitor pops predictions on readdatavalid and checks data and latency.
module tb_system_sysid_ext;

  localparam int          LAT  = 2;
  localparam int          AW   = 4;
  localparam int          FREQ = 4;
  localparam logic [31:0] ID   = 32'hA5A5_0001;
  localparam logic [31:0] TS   = 32'd0;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [31:0]   writedata = 32'd0;
  logic [3:0]    byteenable = 4'd0;
  logic [31:0]   readdata;
  logic          readdatavalid;

  system_sysid_ext #(
    .ID_VALUE     (ID),
    .TIMESTAMP    (TS),
    .ADDR_W       (AW),
    .NUM_SCRATCH  (2),
    .READ_LATENCY (LAT),
    .CLK_FREQ_HZ  (FREQ)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  int          iss_q[$];

  logic [63:0] m_up;
  logic [31:0] m_sh, m_sec;
  int          m_pre;
  logic        m_frz;
  logic [31:0] m_scr[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    case (a)
      4'd0:    return ID;
      4'd1:    return TS;
      4'd2:    return m_up[31:0];
      4'd3:    return m_sh;
      4'd4:    return m_sec;
      4'd5:    return {30'd0, m_frz, 1'b0};
      4'd6:    return m_scr[0];
      4'd7:    return m_scr[1];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_zero();
    m_up = 64'd0; m_sh = 32'd0; m_sec = 32'd0; m_pre = 0; m_frz = 1'b0;
    m_scr[0] = 32'd0; m_scr[1] = 32'd0;
  endtask

  // One bus cycle: drive at negedge, predict, advance model at posedge.
  task automatic bus(input logic rd, input logic wr, input logic [AW-1:0] a,
                     input logic [31:0] wd, input logic [3:0] be);
    logic clr;
    int   idx;
    read = rd; write = wr; address = a; writedata = wd; byteenable = be;
    if (rd) begin
      exp_q.push_back(model_read(a));
      iss_q.push_back(cyc);
    end
    @(posedge clock);
    clr = wr && (a == 4'd5) && be[0] && wd[0];
    if (rd && a == 4'd2) m_sh = m_up[63:32];
    if (clr) begin
      m_up = 64'd0; m_pre = 0; m_sec = 32'd0; m_sh = 32'd0;
    end else if (!m_frz) begin
      m_up = m_up + 64'd1;
      if (m_pre == FREQ - 1) begin
        m_pre = 0; m_sec = m_sec + 32'd1;
      end else begin
        m_pre = m_pre + 1;
      end
    end
    if (wr && a == 4'd5 && be[0]) m_frz = wd[1];
    if (wr && (a == 4'd6 || a == 4'd7)) begin
      idx = int'(a) - 6;
      for (int b = 0; b < 4; b++) if (be[b]) m_scr[idx][8*b +: 8] = wd[8*b +: 8];
    end
    @(negedge clock);
    read = 1'b0; write = 1'b0; byteenable = 4'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) bus(1'b0, 1'b0, '0, 32'd0, 4'd0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    bus(1'b1, 1'b0, a, 32'd0, 4'd0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    bus(1'b0, 1'b1, a, d, be);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    iss_q.delete();
    model_zero();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
  endtask

  logic [31:0] mon_exp;
  int          mon_iss;
  // Monitor: every valid beat must match the oldest prediction with the right latency.
  always @(posedge clock) begin
    #1;
    if (readdatavalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 64'd1, 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_iss = iss_q.pop_front();
        chk("rdata", {32'd0, readdata}, {32'd0, mon_exp});
        chk("latency", 64'(cyc - mon_iss), 64'(LAT));
      end
    end
  end

  initial begin
    @(negedge clock);
    do_reset();
    chk("rst_rdata", {32'd0, readdata}, 64'd0);
    chk("rst_valid", {63'd0, readdatavalid}, 64'd0);

    // ID and TIMESTAMP back to back; stale shadow after reset.
    rd(4'd0);
    rd(4'd1);
    rd(4'd3);
    idle(3);

    // Seconds prescaler, FREEZE, then CLEAR+FREEZE together.
    wr(4'd5, 32'h1, 4'hF);
    idle(10);
    rd(4'd4);
    wr(4'd5, 32'h2, 4'hF);
    idle(20);
    rd(4'd4);
    rd(4'd5);
    wr(4'd5, 32'h3, 4'hF);
    idle(3);
    rd(4'd4);
    rd(4'd2);
    rd(4'd5);
    wr(4'd5, 32'h0, 4'hF);
    idle(2);

    // Uptime snapshot across the 32-bit carry.
    force dut.uptime_q = 64'h0000_0000_FFFF_FFFE;
    m_up = 64'h0000_0000_FFFF_FFFE;
    #1 release dut.uptime_q;
    idle(1);
    rd(4'd2);
    idle(5);
    rd(4'd3);
    rd(4'd2);
    rd(4'd3);
    idle(2);

    // Scratch byte lanes, byteenable=0, unmapped address.
    wr(4'd6, 32'h1234_5678, 4'b1111);
    wr(4'd6, 32'hFFFF_FFFF, 4'b0101);
    rd(4'd6);
    wr(4'd6, 32'h0000_0000, 4'b0000);
    rd(4'd6);
    wr(4'd15, 32'hDEAD_BEEF, 4'hF);
    rd(4'd15);
    rd(4'd6);
    idle(4);
    chk("hold_rdata", {32'd0, readdata}, 64'h12FF_56FF);
    chk("hold_valid", {63'd0, readdatavalid}, 64'd0);

    // Simultaneous read and write on SCRATCH1.
    bus(1'b1, 1'b1, 4'd7, 32'hDEAD_BEEF, 4'hF);
    rd(4'd7);
    idle(3);

    // Reset one cycle after a read: no valid may ever appear for it.
    idle(5);
    rd(4'd0);
    do_reset();
    chk("post_rst_rdata", {32'd0, readdata}, 64'd0);
    chk("post_rst_valid", {63'd0, readdatavalid}, 64'd0);
    rd(4'd2);
    rd(4'd3);
    rd(4'd4);
    rd(4'd5);
    rd(4'd6);
    rd(4'd7);
    idle(5);

    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
